// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART receiver and transmitter.
// Baud divisors assume a 100 MHz system clock.
package uart_pkg;

    localparam int OVS      = 16;
    localparam int MID      = 8;
    localparam int RX_DIV_W = 10;
    localparam int TX_DIV_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // Divisor for the 16x oversampling tick; unused codes fall back to 9600.
    function automatic logic [RX_DIV_W-1:0] rxDivisor(input logic [2:0] baudSet);
        logic [RX_DIV_W-1:0] div;
        case (baudSet)
            3'd0:    div = 10'd651;
            3'd1:    div = 10'd325;
            3'd2:    div = 10'd162;
            3'd3:    div = 10'd108;
            3'd4:    div = 10'd54;
            3'd5:    div = 10'd6;
            default: div = 10'd651;
        endcase
        return div;
    endfunction

    function automatic logic [TX_DIV_W-1:0] txDivisor(input logic [2:0] baudSet);
        logic [TX_DIV_W-1:0] div;
        case (baudSet)
            3'd0:    div = 14'd10417;
            3'd1:    div = 14'd5208;
            3'd2:    div = 14'd2604;
            3'd3:    div = 14'd1736;
            3'd4:    div = 14'd868;
            3'd5:    div = 14'd100;
            default: div = 14'd10417;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator. The rate select is captured on i_clear so
// a rate change on the input only takes effect at the next frame start.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic [2:0] i_baudSet,
    output logic       o_tick
);

    logic [2:0]          r_baud;
    logic [RX_DIV_W-1:0] r_divCnt;
    logic [RX_DIV_W-1:0] w_divLast;

    assign w_divLast = rxDivisor(r_baud) - 1'b1;
    assign o_tick    = (r_divCnt == w_divLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_baud   <= 3'd0;
            r_divCnt <= '0;
        end else if (i_clear) begin
            r_baud   <= i_baudSet;
            r_divCnt <= '0;
        end else if (r_divCnt == w_divLast) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver with 16x oversampling and framing-error detection.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote around mid-bit.
module uart_byte_rx
    import uart_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       uart_rx,
    input  logic [2:0] Baud_set,
    output logic [7:0] Data,
    output logic       Rx_done,
    output logic       Frame_err,
    output logic       Rx_busy
);

    logic r_rxSync1;
    logic r_rxSync2;
    logic r_rxPrev;
    logic w_fallEdge;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= uart_rx;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    assign w_fallEdge = r_rxPrev & ~r_rxSync2;

    logic w_tick;
    logic w_clear;

    uart_baud_tick u_baudTick (
        .i_clk     (Clk),
        .i_rst_n   (Reset_n),
        .i_clear   (w_clear),
        .i_baudSet (Baud_set),
        .o_tick    (w_tick)
    );

    rx_state_t  r_state;
    rx_state_t  w_stateNext;
    logic [3:0] r_smpCnt;
    logic [3:0] w_smpNext;
    logic [2:0] r_bitCnt;
    logic [2:0] w_bitNext;
    logic [7:0] r_shreg;
    logic [7:0] w_shregNext;
    logic [7:0] r_data;
    logic [7:0] w_dataNext;
    logic       r_rxDone;
    logic       w_doneNext;
    logic       r_frameErr;
    logic       w_errNext;
    logic       w_decide;
    logic       w_sample;

    // Sample numbers count ticks within a bit: sample k is the tick that
    // advances r_smpCnt to k, so the 16th tick closes the bit.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_vote;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vote <= 2'b11;
        end else if (w_tick && (r_smpCnt == 4'(MID - 2))) begin
            r_vote[0] <= r_rxSync2;
        end else if (w_tick && (r_smpCnt == 4'(MID - 1))) begin
            r_vote[1] <= r_rxSync2;
        end
    end

    assign w_decide = w_tick && (r_smpCnt == 4'(MID));
    assign w_sample = (r_vote[0] & r_vote[1]) |
                      (r_vote[0] & r_rxSync2) |
                      (r_vote[1] & r_rxSync2);
`else
    assign w_decide = w_tick && (r_smpCnt == 4'(MID - 1));
    assign w_sample = r_rxSync2;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_smpCnt   <= 4'd0;
            r_bitCnt   <= 3'd0;
            r_shreg    <= 8'h00;
            r_data     <= 8'h00;
            r_rxDone   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_smpCnt   <= w_smpNext;
            r_bitCnt   <= w_bitNext;
            r_shreg    <= w_shregNext;
            r_data     <= w_dataNext;
            r_rxDone   <= w_doneNext;
            r_frameErr <= w_errNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_smpNext   = r_smpCnt;
        w_bitNext   = r_bitCnt;
        w_shregNext = r_shreg;
        w_dataNext  = r_data;
        w_doneNext  = 1'b0;
        w_errNext   = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fallEdge) begin
                    w_stateNext = ST_START;
                    w_clear     = 1'b1;
                    w_smpNext   = 4'd0;
                    w_bitNext   = 3'd0;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    w_smpNext = r_smpCnt + 4'd1;
                    if (w_decide && w_sample) begin
                        w_stateNext = ST_IDLE;
                    end else if (r_smpCnt == 4'(OVS - 1)) begin
                        w_stateNext = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    w_smpNext = r_smpCnt + 4'd1;
                    if (w_decide) begin
                        w_shregNext[r_bitCnt] = w_sample;
                    end
                    if (r_smpCnt == 4'(OVS - 1)) begin
                        w_bitNext = r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            w_stateNext = ST_STOP;
                        end
                    end
                end
            end

            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (w_tick) begin
                    w_smpNext = r_smpCnt + 4'd1;
                    if (w_decide) begin
                        w_stateNext = ST_IDLE;
                        if (w_sample) begin
                            w_dataNext = r_shreg;
                            w_doneNext = 1'b1;
                        end else begin
                            w_errNext  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign Data      = r_data;
    assign Rx_done   = r_rxDone;
    assign Frame_err = r_frameErr;
    assign Rx_busy   = (r_state != ST_IDLE);

endmodule
